// File: rtl/operand_issue_pkg.sv
// operand_issue_pkg: shared core sizes and types for the operand-issue stage
package operand_issue_pkg;
    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;
    localparam int CTRL_W   = 16;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [CTRL_W-1:0] ctrl_t;

    // A bus only matches a real register; x0 is never produced by anyone.
    function automatic logic addr_hit(input logic valid, input reg_addr_t rd, input reg_addr_t src);
        return valid && (rd == src) && (src != '0);
    endfunction
endpackage

// File: rtl/operand_issue_scoreboard.sv
// issue_scoreboard: per-register pending bits and RAW/WAW hazard detection
module issue_scoreboard
    import operand_issue_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      set_en,
    input  reg_addr_t set_rd,
    input  logic      clr_en,
    input  reg_addr_t clr_rd,
    input  reg_addr_t rs1,
    input  reg_addr_t rs2,
    input  reg_addr_t rd,
    input  logic      rd_we,
    input  logic      rs1_hit,
    input  logic      rs2_hit,
    output logic      raw,
    output logic      waw
);
    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_nx;
    logic                set_v;
    logic                clr_v;

    assign set_v = set_en && (set_rd != '0);
    assign clr_v = clr_en && (clr_rd != '0);

    // Set is applied after clear so a same-cycle reissue keeps the register pending.
    always_comb begin
        pend_nx = pend_q;
        if (clr_v) pend_nx[clr_rd] = 1'b0;
        if (set_v) pend_nx[set_rd] = 1'b1;
        pend_nx[0] = 1'b0;
    end

    always_ff @(posedge clk) pend_q <= reset ? '0 : pend_nx;

    assign raw = ((rs1 != '0) && pend_q[rs1] && !rs1_hit) ||
                 ((rs2 != '0) && pend_q[rs2] && !rs2_hit);
    assign waw = rd_we && (rd != '0) && pend_q[rd] && !(clr_v && (clr_rd == rd));
endmodule

// File: rtl/operand_issue.sv
// operand_issue: operand forwarding, hazard stall and issue register to execute
module operand_issue
    import operand_issue_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_rd_we,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [REG_AW-1:0] rf_ra_addr,
    output logic [REG_AW-1:0] rf_rb_addr,
    input  logic [WIDTH-1:0]  rf_ra_value,
    input  logic [WIDTH-1:0]  rf_rb_value,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [WIDTH-1:0]  wb_data,
    input  logic              ex_fwd_valid,
    input  logic [REG_AW-1:0] ex_fwd_rd,
    input  logic [WIDTH-1:0]  ex_fwd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_rs1_val,
    output logic [WIDTH-1:0]  out_rs2_val,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_rd_we,
    output logic [CTRL_W-1:0] out_ctrl
);
    logic             ex_hit1, ex_hit2, wb_hit1, wb_hit2;
    logic             raw, waw, accept;
    logic [WIDTH-1:0] rs1_val, rs2_val;

    assign rf_ra_addr = in_rs1;
    assign rf_rb_addr = in_rs2;

    assign ex_hit1 = addr_hit(ex_fwd_valid, ex_fwd_rd, in_rs1);
    assign ex_hit2 = addr_hit(ex_fwd_valid, ex_fwd_rd, in_rs2);
    assign wb_hit1 = addr_hit(wb_valid, wb_rd, in_rs1);
    assign wb_hit2 = addr_hit(wb_valid, wb_rd, in_rs2);

    // Execute result is younger than writeback, so it takes priority.
    assign rs1_val = (in_rs1 == '0) ? '0 : ex_hit1 ? ex_fwd_data : wb_hit1 ? wb_data : rf_ra_value;
    assign rs2_val = (in_rs2 == '0) ? '0 : ex_hit2 ? ex_fwd_data : wb_hit2 ? wb_data : rf_rb_value;

    issue_scoreboard u_sb (
        .clk     (clk),
        .reset   (reset),
        .set_en  (accept && in_rd_we),
        .set_rd  (in_rd),
        .clr_en  (wb_valid),
        .clr_rd  (wb_rd),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .rd      (in_rd),
        .rd_we   (in_rd_we),
        .rs1_hit (ex_hit1 || wb_hit1),
        .rs2_hit (ex_hit2 || wb_hit2),
        .raw     (raw),
        .waw     (waw)
    );

    assign in_ready = !reset && (!out_valid || out_ready) && !raw && !waw;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_rs1_val <= '0;
            out_rs2_val <= '0;
            out_rd      <= '0;
            out_rd_we   <= 1'b0;
            out_ctrl    <= '0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_rs1_val <= rs1_val;
            out_rs2_val <= rs2_val;
            out_rd      <= in_rd;
            out_rd_we   <= in_rd_we;
            out_ctrl    <= in_ctrl;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end
endmodule

// File: doc/operand_issue.md
OPERAND_ISSUE -- requirements
Module: operand_issue

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/data width.
REQ-002 SHALL have port: clk  in  1  clock; all state updates on posedge.
REQ-003 SHALL have port: reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: in_valid in 1, in_ready out 1; decoded-instruction handshake from decode.
REQ-005 SHALL have ports: in_rs1 in 5, in_rs2 in 5, in_rd in 5, in_rd_we in 1, in_ctrl in 16; the ALU/LSU control field is opaque passthrough.
REQ-006 SHALL have ports: rf_ra_addr out 5, rf_rb_addr out 5, rf_ra_value in WIDTH, rf_rb_value in WIDTH; these drive the 2r1w regfile async read ports.
REQ-007 SHALL have ports: wb_valid in 1, wb_rd in 5, wb_data in WIDTH; this is the writeback bus, identical to the regfile write port.
REQ-008 SHALL have ports: ex_fwd_valid in 1, ex_fwd_rd in 5, ex_fwd_data in WIDTH; this is the execute-stage result available this cycle.
REQ-009 SHALL have ports: out_valid out 1, out_ready in 1, out_rs1_val out WIDTH, out_rs2_val out WIDTH, out_rd out 5, out_rd_we out 1, out_ctrl out 16; this is the issue register to execute.

Function
REQ-010 SHALL drive rf_ra_addr=in_rs1 and rf_rb_addr=in_rs2 combinationally.
REQ-011 SHALL resolve each source with priority: x0 -> 0; ex_fwd hit -> ex_fwd_data; wb hit -> wb_data; else regfile value.
- A hit requires the valid bit set, a matching rd, and rd!=0.
REQ-012 SHALL keep a 32-bit scoreboard pend[]; pend[0] is constantly 0.
REQ-013 SHALL set pend[in_rd] on an accepted instruction (in_valid&in_ready) with in_rd_we=1 and in_rd!=0.
REQ-014 SHALL clear pend[wb_rd] when wb_valid=1 and wb_rd!=0.
REQ-015 SHALL let set win when a set and a clear of the same register occur in the same cycle.
REQ-016 SHALL flag a RAW hazard when a nonzero source has pend=1 and no ex_fwd/wb hit for that source.
REQ-017 SHALL flag a WAW hazard when in_rd_we=1, in_rd!=0, pend[in_rd]=1 and there is no wb clear of in_rd this cycle.
REQ-018 SHALL compute in_ready = (!out_valid | out_ready) & !RAW & !WAW; in_ready is combinational and independent of in_valid.
REQ-019 SHALL load the issue register on accept with one cycle latency from acceptance to out_valid.
REQ-020 SHALL hold out_valid and all out_* stable while out_valid=1 and out_ready=0.
REQ-021 SHALL clear out_valid on out_ready when no new instruction is accepted.
REQ-022 SHALL support full throughput of 1 instruction/cycle when hazard-free.
REQ-023 SHALL leave state unchanged for in_valid=0.
REQ-024 SHALL forward wb_data for a source that is both pending and hit by wb in the same cycle, and issue without stall.
REQ-025 SHALL treat in_rd_we=1 with in_rd=0 as no scoreboard effect.

Reset
REQ-026 SHALL, while reset=1 at posedge, clear out_valid, all pend bits, out_rd, out_rd_we, out_ctrl, out_rs1_val and out_rs2_val to 0.
REQ-027 SHALL hold in_ready=0 during the reset cycle.
REQ-028 SHALL discard any in-flight issue register content on reset asserted mid-stall.

Structure
REQ-029 SHALL take WIDTH, the register-address width (5), the register count (32) and the ctrl-field width (16) from the shared core package.
REQ-030 SHALL implement the scoreboard as sub-module issue_scoreboard: pending bits, set/clear ports, and hazard query for rs1/rs2/rd.
REQ-031 SHALL keep the forwarding mux and issue register in operand_issue.

Verification
REQ-032 Independent ops: issue add x3 and sub x4 back-to-back, no pending -> out_valid on consecutive cycles, in_ready constant 1.
REQ-033 Forwarding priority: x5 pending, ex_fwd(x5,0xAAAA0001) and wb(x5,0x11110000) in the same cycle -> out_rs1_val=0xAAAA0001.
REQ-034 Load-use stall: x7 pending, no hit -> in_ready=0 for 3 cycles; then wb(x7,0x1234) -> issue with rs1_val=0x1234, pend[7]=0 next cycle.
REQ-035 Backpressure: out_ready=0 for 4 cycles with out_valid=1 -> out_* unchanged and in_ready=0; out_ready=1 -> next instruction accepted.
REQ-036 x0 and WAW: rs1=0 with ex_fwd(x0,0xFFFF) -> rs1_val=0; rd=x9 with pend[9]=1 and no wb -> stall, released on wb(x9).
REQ-037 Reset mid-stall: reset during a REQ-034 stall -> out_valid=0 and pend all 0 next cycle; first instruction after reset issues without stall.
